// File: rtl/spi_tx_pkg.sv
// Shared types and helpers for the SPI transmit master: FSM states, SPI mode
// encodings and the chip-select index width.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous show-ahead FIFO holding words waiting to be shifted out.
// Pushes while full and pops while empty are ignored.
module spi_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_tx_master.sv
// SPI master transmitter: TX FIFO, half-period divider, mode 0..3 shifter, multi-CS.
// Define SPI_TX_LSB_FIRST_EN to add the lsb_first input (LSB-first frames).
module spi_tx_master
  import spi_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CS_NUM     = 4,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic [cs_width(CS_NUM)-1:0] cs_sel,
`ifdef SPI_TX_LSB_FIRST_EN
  input  logic                        lsb_first,
`endif
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        spi_sclk,
  output logic                        spi_mosi,
  output logic [CS_NUM-1:0]           spi_cs_n
);
  localparam int CS_W  = cs_width(CS_NUM);
  localparam int BIT_W = $clog2(DATA_W);

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  reload_val;
  logic [1:0]        mode_q;
  logic              lsb_in;
  logic              lsb_q;
  logic [DATA_W-1:0] sh;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] head;
  logic [CS_NUM-1:0] cs_dec;
  logic fifo_full, fifo_empty, pop, tick, leading, late_sample, idle_lvl;

`ifdef SPI_TX_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Handshake: a word is accepted on any cycle where wr_valid && wr_ready.
  assign wr_ready    = !fifo_full;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign tick        = (cnt == '0);
  assign pop         = enable && !fifo_empty &&
                       ((state == ST_IDLE) || (state == ST_GAP && tick));
  assign reload_val  = (state == ST_IDLE || pop) ? clk_div : div_q;
  assign late_sample = (mode_q == MODE1) || (mode_q == MODE3);
  assign idle_lvl    = (mode_q == MODE2) || (mode_q == MODE3);
  assign leading     = (spi_sclk == idle_lvl);

  // Out-of-range selects decode to no asserted chip select.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= '0;
      mode_q   <= MODE0;
      lsb_q    <= 1'b0;
      sh       <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      spi_sclk <= cpol;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      done <= 1'b0;
      cnt  <= (state == ST_IDLE || tick) ? reload_val : cnt - 1'b1;
      if (pop) begin
        div_q    <= clk_div;
        mode_q   <= {cpol, cpha};
        lsb_q    <= lsb_in;
        bit_cnt  <= BIT_W'(DATA_W - 1);
        sh       <= cpha ? head : shift_word(head, lsb_in);
        spi_mosi <= cpha ? 1'b0 : out_bit(head, lsb_in);
        spi_sclk <= cpol;
        spi_cs_n <= cs_dec;
        state    <= ST_SETUP;
      end else begin
        case (state)
          ST_IDLE:  spi_sclk <= cpol;
          ST_SETUP: if (tick) state <= ST_SHIFT;
          ST_SHIFT: if (tick) begin
            spi_sclk <= ~spi_sclk;
            if (leading) begin
              if (late_sample) begin
                spi_mosi <= out_bit(sh, lsb_q);
                sh       <= shift_word(sh, lsb_q);
              end
            end else if (bit_cnt == '0) begin
              // Trailing edge of the last bit: SCLK is back at its idle level.
              state <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              if (!late_sample) begin
                spi_mosi <= out_bit(sh, lsb_q);
                sh       <= shift_word(sh, lsb_q);
              end
            end
          end
          ST_HOLD: if (tick) begin
            done     <= 1'b1;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
            state    <= ST_GAP;
          end
          ST_GAP:  if (tick) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master (DATA_W=8, CS_NUM=5, FIFO_DEPTH=4).
// CS_NUM=5 gives a 3-bit cs_sel, so cs_sel=5 addresses an absent slave.
module tb_spi_tx_master;
  localparam int DATA_W = 8;
  localparam int CS_NUM = 5;
  localparam int DIV_W  = 16;
  localparam int FDEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [2:0]       cs_sel = '0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_ready, busy, done, spi_sclk, spi_mosi;
  logic [4:0]       spi_cs_n;
`ifdef SPI_TX_LSB_FIRST_EN
  logic             lsb_first = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  spi_tx_master #(.DATA_W(DATA_W), .CS_NUM(CS_NUM), .DIV_W(DIV_W), .FIFO_DEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel),
`ifdef SPI_TX_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t, want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Slave-side monitor: captures MOSI on SCLK rising edges, counts events.
  logic [31:0] rx_shift = '0;
  int          rx_bits = 0;
  int          mosi_rise_chg = 0;
  int          mosi_fall_chg = 0;
  int          done_cnt = 0;
  logic        sclk_d = 1'b0;
  logic        mosi_d = 1'b0;

  always @(negedge clk) begin
    if (spi_sclk !== sclk_d) begin
      if (spi_sclk === 1'b1) begin
        rx_shift = {rx_shift[30:0], spi_mosi};
        rx_bits++;
        if (spi_mosi !== mosi_d) mosi_rise_chg++;
      end else if (spi_mosi !== mosi_d) begin
        mosi_fall_chg++;
      end
    end
    if (done === 1'b1) done_cnt++;
    sclk_d = spi_sclk;
    mosi_d = spi_mosi;
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int k);
    k = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cpol = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (spi_cs_n !== 5'b11111) begin n_err++; $display("FAIL reset_cs_n: got %b want 11111", spi_cs_n); end
    n_vec++; if (spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    n_vec++; if (spi_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
  endtask

  task automatic test_mode0;
    int k, b0, r0, d0;
    logic [4:0] cs_mid;
    bit ok;
    cpol = 1'b0; cpha = 1'b0; clk_div = 16'd1; cs_sel = 3'd2; enable = 1'b1;
    idle(2);
    b0 = rx_bits; r0 = mosi_rise_chg; d0 = done_cnt;
    push(8'hA5);
    k = -1; cs_mid = 5'b11111;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 10) cs_mid = spi_cs_n;
      if (done === 1'b1) begin k = i; break; end
    end
    n_vec++; if (cs_mid !== 5'b11011) begin n_err++; $display("FAIL m0_cs_n: got %b want 11011", cs_mid); end
    n_vec++; if (k < 37 || k > 39) begin n_err++; $display("FAIL m0_done_latency: got %0d want 37..39", k); end
    wait_idle(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL m0_idle: got busy want idle"); end
    idle(2);
    n_vec++; if (rx_shift[7:0] !== 8'hA5) begin n_err++; $display("FAIL m0_data: got %h want a5", rx_shift[7:0]); end
    n_vec++; if (rx_bits - b0 != 8) begin n_err++; $display("FAIL m0_bits: got %0d want 8", rx_bits - b0); end
    n_vec++; if (mosi_rise_chg - r0 != 0) begin n_err++; $display("FAIL m0_mosi_on_rise: got %0d want 0", mosi_rise_chg - r0); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL m0_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mode3;
    int k, b0, r0, f0;
    bit ok;
    cpol = 1'b1; cpha = 1'b1; clk_div = 16'd0; cs_sel = 3'd0; enable = 1'b1;
    idle(2);
    n_vec++; if (spi_sclk !== 1'b1) begin n_err++; $display("FAIL m3_sclk_idle: got %b want 1", spi_sclk); end
    b0 = rx_bits; r0 = mosi_rise_chg; f0 = mosi_fall_chg;
    push(8'h3C);
    wait_done(100, k);
    n_vec++; if (k < 18 || k > 20) begin n_err++; $display("FAIL m3_done_latency: got %0d want 18..20", k); end
    wait_idle(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL m3_idle: got busy want idle"); end
    idle(2);
    n_vec++; if (rx_shift[7:0] !== 8'h3C) begin n_err++; $display("FAIL m3_data: got %h want 3c", rx_shift[7:0]); end
    n_vec++; if (rx_bits - b0 != 8) begin n_err++; $display("FAIL m3_bits: got %0d want 8", rx_bits - b0); end
    n_vec++; if (mosi_rise_chg - r0 != 0) begin n_err++; $display("FAIL m3_mosi_on_rise: got %0d want 0", mosi_rise_chg - r0); end
    n_vec++; if (mosi_fall_chg - f0 != 2) begin n_err++; $display("FAIL m3_mosi_on_fall: got %0d want 2", mosi_fall_chg - f0); end
    n_vec++; if (spi_sclk !== 1'b1) begin n_err++; $display("FAIL m3_sclk_after: got %b want 1", spi_sclk); end
  endtask

  task automatic test_fifo_fill;
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int at [4];
    int ndone, gap_cnt, d0;
    logic exp_rdy;
    bit ok;
    cpol = 1'b0; cpha = 1'b0; clk_div = 16'd0; cs_sel = 3'd1; enable = 1'b0;
    idle(2);
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_rdy = (i < 4) ? 1'b1 : 1'b0;
      n_vec++; if (wr_ready !== exp_rdy) begin n_err++; $display("FAIL fill_wr_ready[%0d]: got %b want %b", i, wr_ready, exp_rdy); end
      wr_data = words[i]; wr_valid = 1'b1;
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", wr_ready); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fill_busy: got %b want 1", busy); end
    n_vec++; if (spi_cs_n !== 5'b11111) begin n_err++; $display("FAIL fill_cs_disabled: got %b want 11111", spi_cs_n); end
    enable = 1'b1;
    ndone = 0; gap_cnt = 0;
    for (int i = 0; i < 200 && ndone < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin at[ndone] = i; ndone++; end
      if (ndone >= 1 && ndone < 4 && spi_cs_n === 5'b11111) gap_cnt++;
    end
    n_vec++; if (ndone != 4) begin n_err++; $display("FAIL fill_frames: got %0d want 4", ndone); end
    for (int j = 1; j < 4; j++) begin
      n_vec++; if (ndone == 4 && at[j] - at[j-1] != 19) begin n_err++; $display("FAIL fill_period[%0d]: got %0d want 19", j, at[j] - at[j-1]); end
    end
    n_vec++; if (gap_cnt != 3) begin n_err++; $display("FAIL fill_gap_cycles: got %0d want 3", gap_cnt); end
    wait_idle(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fill_idle: got busy want idle"); end
    idle(2);
    n_vec++; if (rx_shift !== 32'h11223344) begin n_err++; $display("FAIL fill_data: got %h want 11223344", rx_shift); end
    n_vec++; if (done_cnt - d0 != 4) begin n_err++; $display("FAIL fill_done_cnt: got %0d want 4", done_cnt - d0); end
  endtask

  task automatic test_enable_drop;
    int k1, k2, k3, b0, d0;
    bit ok;
    cpol = 1'b0; cpha = 1'b0; clk_div = 16'd0; cs_sel = 3'd3; enable = 1'b0;
    idle(2);
    push(8'h81); push(8'h42); push(8'h24);
    b0 = rx_bits; d0 = done_cnt;
    enable = 1'b1;
    wait_done(100, k1);
    idle(5);
    enable = 1'b0;
    wait_done(100, k2);
    n_vec++; if (k1 < 0 || k2 < 0) begin n_err++; $display("FAIL drop_frames12: got %0d/%0d want >=0", k1, k2); end
    idle(40);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy: got %b want 1", busy); end
    n_vec++; if (spi_cs_n !== 5'b11111) begin n_err++; $display("FAIL drop_cs_n: got %b want 11111", spi_cs_n); end
    n_vec++; if (done_cnt - d0 != 2) begin n_err++; $display("FAIL drop_done_cnt: got %0d want 2", done_cnt - d0); end
    n_vec++; if (rx_bits - b0 != 16) begin n_err++; $display("FAIL drop_bits: got %0d want 16", rx_bits - b0); end
    n_vec++; if (rx_shift[15:0] !== 16'h8142) begin n_err++; $display("FAIL drop_data: got %h want 8142", rx_shift[15:0]); end
    enable = 1'b1;
    wait_done(100, k3);
    n_vec++; if (k3 < 0) begin n_err++; $display("FAIL drop_frame3: got %0d want >=0", k3); end
    wait_idle(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drop_idle: got busy want idle"); end
    idle(2);
    n_vec++; if (rx_shift[7:0] !== 8'h24) begin n_err++; $display("FAIL drop_data3: got %h want 24", rx_shift[7:0]); end
  endtask

  task automatic test_reset_mid;
    int d0;
    cpol = 1'b1; cpha = 1'b0; clk_div = 16'd1; cs_sel = 3'd0; enable = 1'b1;
    idle(2);
    push(8'h5A); push(8'h77);
    idle(12);
    n_vec++; if (spi_cs_n !== 5'b11110) begin n_err++; $display("FAIL rstmid_cs_active: got %b want 11110", spi_cs_n); end
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (spi_cs_n !== 5'b11111) begin n_err++; $display("FAIL rstmid_cs_n: got %b want 11111", spi_cs_n); end
    n_vec++; if (spi_sclk !== 1'b1) begin n_err++; $display("FAIL rstmid_sclk: got %b want 1", spi_sclk); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
    idle(60);
    n_vec++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_flushed: got %b want 0", busy); end
  endtask

  task automatic test_cs_out_of_range;
    int k, b0, d0;
    bit cs_low, ok;
    cpol = 1'b0; cpha = 1'b0; clk_div = 16'd0; cs_sel = 3'd5; enable = 1'b1;
    idle(2);
    b0 = rx_bits; d0 = done_cnt;
    push(8'hC3);
    k = -1; cs_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 5'b11111) cs_low = 1'b1;
      if (done === 1'b1) begin k = i; break; end
    end
    n_vec++; if (k < 0) begin n_err++; $display("FAIL oob_done: got %0d want >=0", k); end
    n_vec++; if (cs_low !== 1'b0) begin n_err++; $display("FAIL oob_cs_n: got asserted want 11111"); end
    wait_idle(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL oob_idle: got busy want idle"); end
    idle(2);
    n_vec++; if (rx_shift[7:0] !== 8'hC3) begin n_err++; $display("FAIL oob_data: got %h want c3", rx_shift[7:0]); end
    n_vec++; if (rx_bits - b0 != 8) begin n_err++; $display("FAIL oob_bits: got %0d want 8", rx_bits - b0); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL oob_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_fifo_fill();
    test_enable_drop();
    test_reset_mid();
    test_cs_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
